// File: rtl/car_collision_detector.sv
// Per-frame car/frog collision scanner with lives counter, post-hit grace period and game-over flag.
// Optional COLLISION_EARLY_EXIT_EN: end the scan on the cycle after the first overlap is found.
module car_collision_detector #(
    parameter int NUM_LANES     = 6,
    parameter int CARS_PER_LANE = 3,
    parameter int BLOCKSIZE     = 32,
    parameter int LANE_Y_BASE   = 96,
    parameter int LIVES_INIT    = 3,
    parameter int GRACE_FRAMES  = 60
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         frame_start,
    input  logic         new_game,
    input  logic [9:0]   frog_x,
    input  logic [9:0]   frog_y,
    input  logic [179:0] car_x_flat,
    input  logic [59:0]  lane_len_flat,
    output logic         busy,
    output logic         scan_done,
    output logic         hit,
    output logic [2:0]   hit_lane,
    output logic [1:0]   hit_car,
    output logic [1:0]   lives,
    output logic         game_over
);

    localparam int NUM_CARS = NUM_LANES * CARS_PER_LANE;
    localparam int IW       = $clog2(NUM_CARS);
    localparam int GW       = $clog2(GRACE_FRAMES + 1);

    typedef enum logic [1:0] {IDLE, SNAP, SCAN, REPORT} state_t;

    state_t         state, state_next;
    logic [9:0]     snap_car_x [NUM_CARS];
    logic [9:0]     snap_lane_len [NUM_LANES];
    logic [9:0]     snap_frog_x, snap_frog_y;
    logic [2:0]     scan_lane;
    logic [1:0]     scan_car;
    logic           found;
    logic [2:0]     found_lane;
    logic [1:0]     found_car;
    logic           new_game_pending;
    logic [GW-1:0]  grace;

    logic [9:0]     frog_dy, frog_lane, frog_row_off;
    logic           frog_lane_valid;
    logic [IW-1:0]  cur_idx;
    logic [9:0]     cur_x, cur_len;
    logic [10:0]    car_end, frog_end;
    logic           overlap, last_car, scan_exit;
    logic           any_hit, ng_at_report, ng_immediate, counted;
    logic [2:0]     rep_lane;
    logic [1:0]     rep_car;

    // The frog only shares a lane with cars when its top edge sits exactly on a lane row.
    assign frog_dy         = snap_frog_y - 10'(LANE_Y_BASE);
    assign frog_lane       = frog_dy / 10'(BLOCKSIZE);
    assign frog_row_off    = frog_dy % 10'(BLOCKSIZE);
    assign frog_lane_valid = (snap_frog_y >= 10'(LANE_Y_BASE)) && (frog_row_off == 10'd0)
                             && (frog_lane < 10'(NUM_LANES));

    assign cur_idx  = IW'(scan_lane) * IW'(CARS_PER_LANE) + IW'(scan_car);
    assign cur_x    = snap_car_x[cur_idx];
    assign cur_len  = snap_lane_len[scan_lane];
    assign car_end  = {1'b0, cur_x} + {1'b0, cur_len};
    assign frog_end = {1'b0, snap_frog_x} + 11'(BLOCKSIZE);
    assign overlap  = (state == SCAN) && frog_lane_valid && (frog_lane == 10'(scan_lane))
                      && ({1'b0, snap_frog_x} < car_end) && ({1'b0, cur_x} < frog_end);
    assign last_car = (scan_lane == 3'(NUM_LANES - 1)) && (scan_car == 2'(CARS_PER_LANE - 1));

`ifdef COLLISION_EARLY_EXIT_EN
    assign scan_exit = last_car || overlap;
`else
    assign scan_exit = last_car;
`endif

    // Result is resolved on the edge that enters REPORT, so REPORT-cycle outputs are already valid.
    assign any_hit      = found || overlap;
    assign rep_lane     = found ? found_lane : scan_lane;
    assign rep_car      = found ? found_car : scan_car;
    assign ng_at_report = (state == SCAN) && scan_exit && (new_game_pending || new_game);
    assign ng_immediate = new_game && ((state == IDLE) || (state == REPORT));
    assign counted      = (state == SCAN) && scan_exit && any_hit && !game_over
                          && (grace == '0) && !new_game_pending && !new_game;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (frame_start) state_next = SNAP;
            SNAP:    state_next = SCAN;
            SCAN:    if (scan_exit) state_next = REPORT;
            REPORT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        scan_done = (state == REPORT);
    end

    // Snapshot isolates the scan from position updates made during the frame.
    always_ff @(posedge clk) begin
        if (state == SNAP) begin
            for (int i = 0; i < NUM_CARS; i++) snap_car_x[i] <= car_x_flat[10*i +: 10];
            for (int n = 0; n < NUM_LANES; n++) snap_lane_len[n] <= lane_len_flat[10*n +: 10];
            snap_frog_x <= frog_x;
            snap_frog_y <= frog_y;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_lane        <= '0;
            scan_car         <= '0;
            found            <= 1'b0;
            found_lane       <= '0;
            found_car        <= '0;
            new_game_pending <= 1'b0;
        end else begin
            case (state)
                SNAP: begin
                    scan_lane        <= '0;
                    scan_car         <= '0;
                    found            <= 1'b0;
                    new_game_pending <= new_game;
                end
                SCAN: begin
                    if (overlap && !found) begin
                        found      <= 1'b1;
                        found_lane <= scan_lane;
                        found_car  <= scan_car;
                    end
                    if (scan_car == 2'(CARS_PER_LANE - 1)) begin
                        scan_car  <= '0;
                        scan_lane <= scan_lane + 3'd1;
                    end else begin
                        scan_car <= scan_car + 2'd1;
                    end
                    new_game_pending <= scan_exit ? 1'b0 : (new_game_pending || new_game);
                end
                default: new_game_pending <= 1'b0;
            endcase
        end
    end

    // A restart always wins over a hit; grace keeps counting frames even during game over.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit       <= 1'b0;
            hit_lane  <= '0;
            hit_car   <= '0;
            lives     <= 2'(LIVES_INIT);
            game_over <= 1'b0;
            grace     <= '0;
        end else begin
            hit <= counted;
            if (ng_immediate || ng_at_report) begin
                lives     <= 2'(LIVES_INIT);
                game_over <= 1'b0;
                grace     <= '0;
            end else if (counted) begin
                lives     <= (lives == 2'd0) ? 2'd0 : lives - 2'd1;
                game_over <= (lives <= 2'd1);
                grace     <= GW'(GRACE_FRAMES);
                hit_lane  <= rep_lane;
                hit_car   <= rep_car;
            end else begin
                if (frame_start && (grace != '0)) grace <= grace - GW'(1);
                game_over <= (lives == 2'd0);
            end
        end
    end

endmodule

// File: tb/tb_car_collision_detector.sv
// Randomized self-checking bench for car_collision_detector against a frame-level reference model.
// Honours COLLISION_EARLY_EXIT_EN for the expected scan latency.
module tb_car_collision_detector;

    localparam int NL  = 6;
    localparam int CPL = 3;
    localparam int NC  = NL * CPL;
    localparam int BS  = 32;
    localparam int LYB = 96;
    localparam int LI  = 3;
    localparam int GF  = 60;

    logic         clk = 1'b0;
    logic         reset, frame_start, new_game;
    logic [9:0]   frog_x, frog_y;
    logic [179:0] car_x_flat;
    logic [59:0]  lane_len_flat;
    logic         busy, scan_done, hit, game_over;
    logic [2:0]   hit_lane;
    logic [1:0]   hit_car, lives;

    int vectorCount = 0;
    int missCount   = 0;
    int sceneCarX[NC];
    int sceneLen[NL];
    int sceneFx, sceneFy;
    int mLives, mGrace, mLane, mCar;
    bit mGo;

    car_collision_detector dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .new_game(new_game),
        .frog_x(frog_x), .frog_y(frog_y), .car_x_flat(car_x_flat), .lane_len_flat(lane_len_flat),
        .busy(busy), .scan_done(scan_done), .hit(hit), .hit_lane(hit_lane), .hit_car(hit_car),
        .lives(lives), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < NC; i++) car_x_flat[10*i +: 10] = 10'(sceneCarX[i]);
        for (int n = 0; n < NL; n++) lane_len_flat[10*n +: 10] = 10'(sceneLen[n]);
        frog_x = 10'(sceneFx);
        frog_y = 10'(sceneFy);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Lowest car index whose span overlaps the frog in the frog's lane, or -1.
    function automatic int firstHit();
        int fl = -1;
        if (sceneFy >= LYB && (sceneFy - LYB) % BS == 0 && (sceneFy - LYB) / BS < NL)
            fl = (sceneFy - LYB) / BS;
        for (int i = 0; i < NC; i++)
            if (i / CPL == fl && sceneFx < sceneCarX[i] + sceneLen[i / CPL] && sceneCarX[i] < sceneFx + BS)
                return i;
        return -1;
    endfunction

    task automatic modelReset();
        mLives = LI; mGrace = 0; mGo = 0; mLane = 0; mCar = 0;
    endtask

    task automatic quietScene(input int fx, input int fy);
        for (int i = 0; i < NC; i++) sceneCarX[i] = 1000;
        for (int n = 0; n < NL; n++) sceneLen[n] = 10;
        sceneFx = fx;
        sceneFy = fy;
    endtask

    task automatic lane2Scene(input int fx);
        quietScene(fx, 160);
        sceneCarX[6] = 180;
        sceneLen[2]  = 96;
    endtask

    task automatic randomScene();
        for (int i = 0; i < NC; i++) sceneCarX[i] = $urandom_range(0, 1023);
        for (int n = 0; n < NL; n++) sceneLen[n] = ($urandom_range(0, 15) == 0) ? 1023 : $urandom_range(0, 300);
        sceneFx = $urandom_range(0, 1023);
        sceneFy = ($urandom_range(0, 9) < 7) ? LYB + BS * $urandom_range(0, 6) : $urandom_range(0, 1023);
    endtask

    task automatic runFrame(input bit ngStart, input bit ngMid, input bit extraStart);
        int fh, cycles, expCycles;
        bit expHit;
        @(negedge clk);
        applyStimulus();
        frame_start = 1'b1;
        new_game    = ngStart;
        fh = firstHit();
        if (ngStart) begin
            mLives = LI; mGo = 0; mGrace = 0;
        end else if (mGrace > 0) mGrace--;
        tick();
        cycles = 1;
        checkOutput("busy_snap", 32'(busy), 1);
        frame_start = extraStart;
        new_game    = ngMid;
        if (extraStart && mGrace > 0) mGrace--;
        tick();
        cycles = 2;
        frame_start = 1'b0;
        new_game    = 1'b0;
        for (int i = 0; i < NC; i++) car_x_flat[10*i +: 10] = 10'($urandom);
        for (int n = 0; n < NL; n++) lane_len_flat[10*n +: 10] = 10'($urandom);
        frog_x = 10'($urandom);
        frog_y = 10'($urandom);
        while (scan_done !== 1'b1 && cycles < 40) begin
            tick();
            cycles++;
        end
        expHit = (fh >= 0) && !ngMid && !mGo && mGrace == 0;
        if (ngMid) begin
            mLives = LI; mGo = 0; mGrace = 0;
        end else if (expHit) begin
            mLives--; mGrace = GF; mGo = (mLives == 0); mLane = fh / CPL; mCar = fh % CPL;
        end
        expCycles = 20;
`ifdef COLLISION_EARLY_EXIT_EN
        if (fh >= 0) expCycles = 3 + fh;
`endif
        checkOutput("latency", 32'(cycles), 32'(expCycles));
        checkOutput("hit", 32'(hit), 32'(expHit));
        checkOutput("hit_lane", 32'(hit_lane), 32'(mLane));
        checkOutput("hit_car", 32'(hit_car), 32'(mCar));
        checkOutput("lives", 32'(lives), 32'(mLives));
        checkOutput("game_over", 32'(game_over), 32'(mGo));
        tick();
        checkOutput("scan_done_pulse", 32'(scan_done), 0);
        checkOutput("hit_pulse", 32'(hit), 0);
        tick();
        checkOutput("idle_after", 32'(busy), 0);
    endtask

    initial begin
        int doneCount;
        reset = 1'b1; frame_start = 1'b0; new_game = 1'b0;
        quietScene(200, 40);
        applyStimulus();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_scan_done", 32'(scan_done), 0);
        checkOutput("rst_hit", 32'(hit), 0);
        checkOutput("rst_lives", 32'(lives), 3);
        checkOutput("rst_game_over", 32'(game_over), 0);

        quietScene(200, 40);
        runFrame(0, 0, 0);
        lane2Scene(200);
        repeat (3) runFrame(0, 0, 0);

        quietScene(200, 40);
        repeat (60) runFrame(0, 0, 0);
        lane2Scene(276);
        runFrame(0, 0, 0);
        lane2Scene(275);
        runFrame(0, 0, 0);
        quietScene(200, 40);
        repeat (61) runFrame(0, 0, 0);
        lane2Scene(200);
        runFrame(0, 0, 0);
        runFrame(0, 0, 0);
        quietScene(200, 40);
        runFrame(1, 0, 0);

        lane2Scene(200);
        @(negedge clk);
        applyStimulus();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (6) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        modelReset();
        checkOutput("midrst_busy", 32'(busy), 0);
        checkOutput("midrst_hit_lane", 32'(hit_lane), 0);
        checkOutput("midrst_hit_car", 32'(hit_car), 0);
        checkOutput("midrst_lives", 32'(lives), 3);
        checkOutput("midrst_game_over", 32'(game_over), 0);
        doneCount = 0;
        repeat (25) begin
            tick();
            if (scan_done === 1'b1) doneCount++;
        end
        checkOutput("midrst_no_done", 32'(doneCount), 0);

        quietScene(200, 40);
        runFrame(0, 0, 1);
        doneCount = 0;
        repeat (25) begin
            tick();
            if (scan_done === 1'b1) doneCount++;
        end
        checkOutput("busy_start_ignored", 32'(doneCount), 0);

        lane2Scene(200);
        runFrame(0, 1, 0);

        for (int f = 0; f < 300; f++) begin
            randomScene();
            runFrame($urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
